reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the clock-manager reset (high while the DCM is unlocked) and CLK_50MHZ.
//  Synchronises reset release, holds a settle period, then releases peripheral reset before CPU reset.
//  Also folds in a debounced push-button reset and records the cause of the last reset.
//  Sits between the clock divider and every CPU/memory/video block in the 50 MHz domain.
// PARAMETERS
//  SYNC_STAGES      2       flops in the reset-release and button synchronisers (>=2)
//  HOLD_CYCLES      16      cycles held in reset after synchronised release (>=1)
//  STAGGER_CYCLES   8       cycles between rst_periph release and rst_cpu release (>=1)
//  DEBOUNCE_CYCLES  250000  consecutive synchronised-high cycles that qualify a button press (5 ms)
//  WDT_CYCLES       2**24   watchdog timeout in cycles (used only with RST_WATCHDOG_EN)
// PORTS
//  clock        in   1  CLK_50MHZ system clock
//  reset        in   1  asynchronous, active-high; driven by the clock manager (~locked)
//  btn_reset    in   1  raw push-button, active-high, asynchronous to clock
//  wdt_kick     in   1  CPU watchdog strobe, 1-cycle pulse
//  rst_periph   out  1  active-high reset for memory/video/IO
//  rst_cpu      out  1  active-high reset for CPU core
//  sys_ready    out  1  high only in RUN
//  reset_cause  out  2  00 power/lock-loss, 01 button, 10 watchdog, 11 reserved
// BEHAVIOUR
//  - Clock/reset: one clock. reset is asynchronous, active-high: it asserts immediately and releases
//    through the SYNC_STAGES synchroniser.
//  - reset high (async): state=ASSERT, all counters=0, synchronisers=0.
//    Outputs: rst_periph=1, rst_cpu=1, sys_ready=0, reset_cause=00. All outputs are registered.
//  - Synchroniser: chain shifts in 1 while reset is low; sync_ok = last stage.
//  - FSM states: ASSERT -> HOLD -> REL_PERIPH -> RUN.
//    ASSERT: leave to HOLD when sync_ok=1 and the synchronised button is 0; clear cnt.
//    HOLD: cnt increments each cycle; at cnt==HOLD_CYCLES-1 go to REL_PERIPH, rst_periph<=0, cnt<=0.
//    REL_PERIPH: at cnt==STAGGER_CYCLES-1 go to RUN, rst_cpu<=0, sys_ready<=1.
//    RUN: stay until a reset event occurs.
//  - Latency, with defaults, from the first rising edge at which reset is sampled low:
//    rst_periph falls at edge SYNC_STAGES+HOLD_CYCLES+1 (=19).
//    rst_cpu and sys_ready rise/fall together at edge +STAGGER_CYCLES later (=27).
//  - Button path: btn_reset goes through SYNC_STAGES flops, then a debounce counter.
//    Any synchronised 0 clears the counter. Reaching DEBOUNCE_CYCLES-1 with input 1 raises a
//    1-cycle press event; no further event until the synchronised input returns to 0.
//  - Press event in HOLD/REL_PERIPH/RUN: next state ASSERT.
//    rst_periph=rst_cpu=1, sys_ready=0, reset_cause<=01.
//    A press event in ASSERT leaves state unchanged and sets cause to 01.
//  - reset_cause holds its value through the sequence and in RUN. Only async reset or a new event
//    changes it.
//  - Button held: ASSERT persists until release; the sequence restarts from HOLD with full
//    HOLD_CYCLES.
//  - Mid-sequence reset assertion: immediate return to ASSERT, regardless of state or counter value.
//  - Counter widths: $clog2 of the largest parameter in use; no wrap is reachable.
// CONFIGURATION
//  RST_WATCHDOG_EN defined:
//    - wdt counter runs only in RUN; it is cleared on wdt_kick and on every state exit.
//    - At WDT_CYCLES-1 without a kick: next state ASSERT, reset_cause<=10.
//    - wdt_kick and timeout in the same cycle: the kick wins, no reset.
//    - Watchdog timeout and button event in the same cycle: button wins, cause=01.
//  RST_WATCHDOG_EN undefined:
//    - No watchdog counter; wdt_kick is ignored.
//    - reset_cause never takes the value 10.
// STRUCTURE
//  reset_seq_pkg:
//    - state encodings ST_ASSERT/ST_HOLD/ST_REL_PERIPH/ST_RUN
//    - cause codes CAUSE_POR=2'b00, CAUSE_BTN=2'b01, CAUSE_WDT=2'b10
//  Sub-module sync_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES):
//    - holds the button synchroniser and debounce counter
//    - outputs btn_sync and press_evt
//  FSM, hold/stagger counter and watchdog are in reset_sequencer.
// TESTING
//  1. Hold reset for 10 cycles, then release -> rst_periph falls at edge 19, rst_cpu/sys_ready at
//     edge 27, cause=00.
//  2. In RUN, pulse btn_reset 1000 cycles (DEBOUNCE_CYCLES=50 override) with a 1-cycle low at 30
//     -> no reset until 50 clean highs. Then both resets=1 and cause=01; after release the full
//     sequence repeats.
//  3. Assert reset during REL_PERIPH at cnt=3 -> rst_periph=1 in the same cycle (async) and
//     cause=00; the sequence restarts from zero.
//  4. RST_WATCHDOG_EN, WDT_CYCLES=100, no kicks -> reset at RUN+100 with cause=10. Kick every 90
//     cycles -> no reset over 1000 cycles. Kick coincident with timeout -> no reset.
//  5. Button event and watchdog timeout in the same cycle -> cause=01. Without RST_WATCHDOG_EN,
//     wdt_kick toggling -> no effect.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, reset-cause codes
// and the counter-sizing helper used by the sequencer and its button debouncer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT     = 2'd0,
        ST_HOLD       = 2'd1,
        ST_REL_PERIPH = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_BTN  = 2'b01,
        CAUSE_WDT  = 2'b10,
        CAUSE_RSVD = 2'b11
    } cause_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold values 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer signal bundle: button and watchdog inputs plus the staged
// reset outputs and last-reset cause; master is the sequencer, slave its user.
interface reset_sequencer_if;

    logic       btn_reset;
    logic       wdt_kick;
    logic       rst_periph;
    logic       rst_cpu;
    logic       sys_ready;
    logic [1:0] reset_cause;

    modport master (
        input  btn_reset,
        input  wdt_kick,
        output rst_periph,
        output rst_cpu,
        output sys_ready,
        output reset_cause
    );

    modport slave (
        output btn_reset,
        output wdt_kick,
        input  rst_periph,
        input  rst_cpu,
        input  sys_ready,
        input  reset_cause
    );

endinterface

// File: rtl/sync_debounce.sv
// Push-button synchroniser and debouncer: emits a single-cycle press event once
// the synchronised button has been high for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_reset,
    output logic btn_sync,
    output logic press_evt
);

    localparam int                DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] btn_chain;
    logic [DB_W-1:0]        db_cnt;
    logic                   fired;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_chain <= '0;
        end else begin
            btn_chain <= {btn_chain[SYNC_STAGES-2:0], btn_reset};
        end
    end

    assign btn_sync  = btn_chain[SYNC_STAGES-1];
    assign press_evt = btn_sync && !fired && (db_cnt == DB_LAST);

    // fired blocks repeat events until the button is seen low again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            fired  <= 1'b0;
        end else if (!btn_sync) begin
            db_cnt <= '0;
            fired  <= 1'b0;
        end else if (press_evt) begin
            fired  <= 1'b1;
        end else if (!fired) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the 50 MHz domain: peripherals leave reset before the CPU,
// a debounced button re-enters reset, and RST_WATCHDOG_EN adds a CPU watchdog.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int WDT_CYCLES      = 2**24
) (
    input  logic               clock,
    input  logic               reset,
    reset_sequencer_if.master  bus
);

    localparam int                CNT_W      = cnt_width(max2(HOLD_CYCLES, STAGGER_CYCLES));
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    cause_t                 cause;
    cause_t                 cause_next;
    logic                   rst_periph_q;
    logic                   rst_cpu_q;
    logic                   sys_ready_q;
    logic [SYNC_STAGES-1:0] rel_chain;
    logic                   sync_ok;
    logic                   btn_sync;
    logic                   press_evt;
    logic                   wdt_timeout;

    // Reset asserts asynchronously; release ripples through the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rel_chain <= '0;
        end else begin
            rel_chain <= {rel_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = rel_chain[SYNC_STAGES-1];

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clock     (clock),
        .reset     (reset),
        .btn_reset (bus.btn_reset),
        .btn_sync  (btn_sync),
        .press_evt (press_evt)
    );

`ifdef RST_WATCHDOG_EN
    localparam int               WDT_W    = cnt_width(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // A kick in the timeout cycle wins; the counter only runs while staying in RUN.
    assign wdt_timeout = (state == ST_RUN) && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_cnt <= '0;
        end else if (state != ST_RUN || state_next != ST_RUN || bus.wdt_kick) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end
`else
    logic unused_wdt;

    assign wdt_timeout = 1'b0;
    assign unused_wdt  = bus.wdt_kick ^ WDT_CYCLES[0];
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cause_next = cause;

        case (state)
            ST_ASSERT: begin
                cnt_next = '0;
                if (sync_ok && !btn_sync) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = ST_REL_PERIPH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_REL_PERIPH: begin
                if (cnt == STAG_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
            end
        endcase

        // Button outranks the watchdog when both fire together.
        if (press_evt) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            cause_next = CAUSE_BTN;
        end else if (wdt_timeout) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            cause_next = CAUSE_WDT;
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_ASSERT;
            cnt          <= '0;
            cause        <= CAUSE_POR;
            rst_periph_q <= 1'b1;
            rst_cpu_q    <= 1'b1;
            sys_ready_q  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            cause        <= cause_next;
            rst_periph_q <= (state_next == ST_ASSERT) || (state_next == ST_HOLD);
            rst_cpu_q    <= (state_next != ST_RUN);
            sys_ready_q  <= (state_next == ST_RUN);
        end
    end

    assign bus.rst_periph  = rst_periph_q;
    assign bus.rst_cpu     = rst_cpu_q;
    assign bus.sys_ready   = sys_ready_q;
    assign bus.reset_cause = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up latency, debounced button reset,
// async reset mid-sequence, and watchdog behaviour when RST_WATCHDOG_EN is defined.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   auto_kick;
    int   kick_ctr;
    bit   rst_seen;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .SYNC_STAGES     (2),
        .HOLD_CYCLES     (16),
        .STAGGER_CYCLES  (8),
        .DEBOUNCE_CYCLES (50),
        .WDT_CYCLES      (100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_kick) begin
            kick_ctr++;
            bus.wdt_kick = (kick_ctr % 40 == 0);
        end
    endtask

    // Steps e_c edges from the current point and checks the two release edges.
    task automatic run_release(input string tag, input int e_p, input int e_c,
                               input logic [1:0] cause_exp);
        for (int e = 1; e <= e_c; e++) begin
            tick();
            if (e == e_p - 1) check({tag, "_periph_held"}, 32'(bus.rst_periph), 1);
            if (e == e_p)     check({tag, "_periph_rel"}, 32'(bus.rst_periph), 0);
            if (e == e_c - 1) begin
                check({tag, "_cpu_held"}, 32'(bus.rst_cpu), 1);
                check({tag, "_ready_low"}, 32'(bus.sys_ready), 0);
            end
            if (e == e_c) begin
                check({tag, "_cpu_rel"}, 32'(bus.rst_cpu), 0);
                check({tag, "_ready_high"}, 32'(bus.sys_ready), 1);
                check({tag, "_cause"}, 32'(bus.reset_cause), 32'(cause_exp));
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.btn_reset = 1'b0;
        bus.wdt_kick  = 1'b0;
        auto_kick     = 1'b1;
        kick_ctr      = 0;
        rst_seen      = 1'b0;

        // Power-up: reset held 10 cycles, then staged release.
        repeat (10) tick();
        check("por_periph", 32'(bus.rst_periph), 1);
        check("por_cpu", 32'(bus.rst_cpu), 1);
        check("por_ready", 32'(bus.sys_ready), 0);
        check("por_cause", 32'(bus.reset_cause), 32'(CAUSE_POR));
        reset = 1'b0;
        run_release("por", 19, 27, CAUSE_POR);

        // Button with a one-cycle glitch: event only after 50 clean synchronised highs.
        bus.btn_reset = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            tick();
            if (e == 30) bus.btn_reset = 1'b0;
            if (e == 31) bus.btn_reset = 1'b1;
            if (e == 52) check("btn_glitch_no_rst", 32'(bus.rst_cpu), 0);
            if (e == 82) check("btn_pre_evt", 32'(bus.rst_cpu), 0);
            if (e == 83) begin
                check("btn_periph", 32'(bus.rst_periph), 1);
                check("btn_cpu", 32'(bus.rst_cpu), 1);
                check("btn_ready", 32'(bus.sys_ready), 0);
                check("btn_cause", 32'(bus.reset_cause), 32'(CAUSE_BTN));
            end
            if (e == 1000) check("btn_held_assert", 32'(bus.rst_periph), 1);
        end
        bus.btn_reset = 1'b0;
        run_release("btn_rel", 19, 27, CAUSE_BTN);

        // Second press, then async reset while in REL_PERIPH with cnt=3.
        auto_kick     = 1'b0;
        bus.wdt_kick  = 1'b0;
        bus.btn_reset = 1'b1;
        for (int e = 1; e <= 82; e++) begin
            tick();
            if (e == 60) bus.btn_reset = 1'b0;
            if (e == 52) check("press2_cpu", 32'(bus.rst_cpu), 1);
            if (e == 78) check("press2_hold", 32'(bus.rst_periph), 1);
            if (e == 82) begin
                check("press2_relp_periph", 32'(bus.rst_periph), 0);
                check("press2_relp_cpu", 32'(bus.rst_cpu), 1);
                check("press2_cause", 32'(bus.reset_cause), 32'(CAUSE_BTN));
            end
        end
        reset = 1'b1;
        #1;
        check("async_periph", 32'(bus.rst_periph), 1);
        check("async_cpu", 32'(bus.rst_cpu), 1);
        check("async_cause", 32'(bus.reset_cause), 32'(CAUSE_POR));
        repeat (3) tick();
        reset = 1'b0;
        run_release("async_rel", 19, 27, CAUSE_POR);

`ifdef RST_WATCHDOG_EN
        // No kicks: timeout on the 100th RUN cycle.
        repeat (99) tick();
        check("wdt_pre", 32'(bus.rst_cpu), 0);
        tick();
        check("wdt_fire_cpu", 32'(bus.rst_cpu), 1);
        check("wdt_fire_cause", 32'(bus.reset_cause), 32'(CAUSE_WDT));
        run_release("wdt_rel", 17, 25, CAUSE_WDT);

        // Kicks every 90 cycles hold off the watchdog.
        rst_seen = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            bus.wdt_kick = (i % 90 == 0);
            tick();
            if (bus.rst_cpu) rst_seen = 1'b1;
        end
        bus.wdt_kick = 1'b0;
        check("wdt_kicked", 32'(rst_seen), 0);

        // Kick in the timeout cycle wins.
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        repeat (99) tick();
        check("wdt_coinc_pre", 32'(bus.rst_cpu), 0);
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        check("wdt_coinc_kick", 32'(bus.rst_cpu), 0);

        // Button event lands in the watchdog timeout cycle: button cause wins.
        repeat (48) tick();
        bus.btn_reset = 1'b1;
        repeat (51) tick();
        check("tie_pre", 32'(bus.rst_cpu), 0);
        tick();
        check("tie_cpu", 32'(bus.rst_cpu), 1);
        check("tie_cause", 32'(bus.reset_cause), 32'(CAUSE_BTN));
        bus.btn_reset = 1'b0;
        run_release("tie_rel", 19, 27, CAUSE_BTN);
`else
        // Without the watchdog, kicks have no effect.
        auto_kick = 1'b1;
        kick_ctr  = 0;
        rst_seen  = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.rst_cpu) rst_seen = 1'b1;
        end
        check("nowdt_no_rst", 32'(rst_seen), 0);
        check("nowdt_ready", 32'(bus.sys_ready), 1);
        check("nowdt_cause", 32'(bus.reset_cause), 32'(CAUSE_POR));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
